irq_unit: RTL

- Parametrised, multi-mode cartridge IRQ generator clocked by CPU M2.
- Replaces the per-mapper IRQ logic with one shared block. Covers MMC3-style PPU A12 scanline counting, VRC4-style prescaled/cycle counting, and Sunsoft-style wide M2 down-counting.
- Mapper decode feeds register writes through a single strobe/select/data port. The block drives the cartridge IRQ line.

---
 rtl/irq_unit.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/irq_unit.sv
// Shared cartridge IRQ generator: MMC3 A12 scanline counter, VRC4 prescaled/cycle
// counter and Sunsoft wide M2 down-counter behind one register write port.
module irq_unit #(
  parameter int COUNTER_WIDTH = 16,
  parameter int A12_FILTER    = 3,
  parameter bit MMC3_ALT      = 1'b0,
  parameter int VRC4_PRESCALE = 341
) (
  input  logic                     m2,
  input  logic                     rst_n,
  input  logic                     ppu_a12,
  input  logic [1:0]               mode,
  input  logic                     reg_we,
  input  logic [2:0]               reg_sel,
  input  logic [7:0]               reg_data,
  output logic                     irq,
  output logic [COUNTER_WIDTH-1:0] counter_out
);

  localparam int CW = COUNTER_WIDTH;
  // latch is kept at least 16 bits wide so the high-byte write is always a legal slice
  localparam int LW = (CW < 16) ? 16 : CW;
  localparam int PW = $clog2(VRC4_PRESCALE + 1);

  localparam logic [PW-1:0] PRESC_RELOAD = PW'(VRC4_PRESCALE);
  localparam logic [PW-1:0] PRESC_WRAP   = PW'(VRC4_PRESCALE - 3);
  localparam logic [PW-1:0] PRESC_STEP   = PW'(3);
  localparam logic [2:0]    FILTER_TH    = 3'(A12_FILTER);
  localparam logic [CW-1:0] LOW_MASK     = CW'(8'hFF);

  localparam logic [1:0] MODE_MMC3 = 2'd0;
  localparam logic [1:0] MODE_VRC4 = 2'd1;
  localparam logic [1:0] MODE_SUN  = 2'd2;
  localparam logic [1:0] MODE_OFF  = 2'd3;

  logic          a12_p0, a12_p1, a12_p2;
  logic [2:0]    low_cnt;
  logic [CW-1:0] counter, counter_n;
  logic [LW-1:0] latch, latch_n;
  logic [PW-1:0] presc, presc_n;
  logic          enable, enable_n;
  logic          enable_after_ack, enable_after_ack_n;
  logic          cycle_mode, cycle_mode_n;
  logic          count_en, count_en_n;
  logic          reload_flag, reload_flag_n;
  logic          pending_n;
  logic [1:0]    mode_q;

  logic          a12_event, mode_chg, load, set_pend, clr_pend, vrc_clk;
  logic [7:0]    old8, new8;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  // Replace the low byte only; modes 0/1 never touch the upper counter bits.
  function automatic logic [CW-1:0] merge8(input logic [CW-1:0] c, input logic [7:0] lo);
    return (c & ~LOW_MASK) | CW'(lo);
  endfunction

  assign a12_event   = a12_p1 & ~a12_p2 & (low_cnt >= FILTER_TH);
  assign mode_chg    = (mode != mode_q);
  assign counter_out = counter;

  always_comb begin
    latch_n            = latch;
    counter_n          = counter;
    presc_n            = presc;
    enable_n           = enable;
    enable_after_ack_n = enable_after_ack;
    cycle_mode_n       = cycle_mode;
    count_en_n         = count_en;
    reload_flag_n      = reload_flag;
    load               = 1'b0;
    set_pend           = 1'b0;
    clr_pend           = 1'b0;
    vrc_clk            = 1'b0;
    old8               = counter[7:0];
    new8               = 8'd0;

    // Counting first; a counter-loading write below overrides it on the same edge.
    if (!mode_chg) begin
      case (mode)
        MODE_MMC3: begin
          if (a12_event) begin
            if ((old8 == 8'd0) || reload_flag) begin
              new8          = latch[7:0];
              reload_flag_n = 1'b0;
            end else begin
              new8 = old8 - 8'd1;
            end
            counter_n = merge8(counter, new8);
            if ((new8 == 8'd0) && enable && (!MMC3_ALT || (old8 != 8'd0) || reload_flag))
              set_pend = 1'b1;
          end
        end
        MODE_VRC4: begin
          if (enable) begin
            if (cycle_mode) begin
              vrc_clk = 1'b1;
            end else if (presc < PRESC_STEP) begin
              presc_n = presc + PRESC_WRAP;
              vrc_clk = 1'b1;
            end else begin
              presc_n = presc - PRESC_STEP;
            end
            if (vrc_clk) begin
              if (old8 == 8'hFF) begin
                counter_n = merge8(counter, latch[7:0]);
                set_pend  = 1'b1;
              end else begin
                counter_n = merge8(counter, old8 + 8'd1);
              end
            end
          end
        end
        MODE_SUN: begin
          if (count_en) begin
            counter_n = counter - CW'(1);
            if ((counter == '0) && enable)
              set_pend = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (reg_we) begin
      case (reg_sel)
        3'd0: latch_n[7:0]  = reg_data;
        3'd1: latch_n[15:8] = reg_data;
        3'd2: begin
          enable_n           = reg_data[0];
          enable_after_ack_n = reg_data[1];
          cycle_mode_n       = reg_data[2];
          count_en_n         = reg_data[3];
          if (mode == MODE_VRC4) begin
            counter_n = merge8(counter, latch[7:0]);
            presc_n   = PRESC_RELOAD;
            clr_pend  = 1'b1;
            load      = 1'b1;
          end
        end
        3'd3: begin
          case (mode)
            MODE_MMC3: begin
              reload_flag_n = 1'b1;
              counter_n     = merge8(counter, 8'd0);
              load          = 1'b1;
            end
            MODE_VRC4: begin
              counter_n = merge8(counter, latch[7:0]);
              load      = 1'b1;
            end
            MODE_SUN: begin
              counter_n = latch[CW-1:0];
              load      = 1'b1;
            end
            default: ;
          endcase
        end
        3'd4: begin
          case (mode)
            MODE_MMC3: begin
              enable_n = 1'b0;
              clr_pend = 1'b1;
            end
            MODE_VRC4: begin
              enable_n = enable_after_ack;
              clr_pend = 1'b1;
            end
            MODE_SUN: clr_pend = 1'b1;
            default: ;
          endcase
        end
        3'd5: if (mode == MODE_MMC3) enable_n = 1'b1;
        default: ;
      endcase
    end

    if (load) set_pend = 1'b0;

    // A set on the same edge as an acknowledge wins so no interrupt is lost.
    pending_n = ~irq;
    if (clr_pend) pending_n = 1'b0;
    if (set_pend) pending_n = 1'b1;
    if (mode == MODE_OFF) pending_n = 1'b0;
    if (mode_chg) begin
      pending_n     = 1'b0;
      reload_flag_n = 1'b0;
      presc_n       = PRESC_RELOAD;
    end
  end

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      a12_p0           <= 1'b0;
      a12_p1           <= 1'b0;
      a12_p2           <= 1'b0;
      low_cnt          <= 3'd0;
      counter          <= '0;
      latch            <= '0;
      presc            <= PRESC_RELOAD;
      enable           <= 1'b0;
      enable_after_ack <= 1'b0;
      cycle_mode       <= 1'b0;
      count_en         <= 1'b0;
      reload_flag      <= 1'b0;
      mode_q           <= MODE_MMC3;
      irq              <= 1'b1;
    end else begin
      a12_p0           <= ppu_a12;
      a12_p1           <= a12_p0;
      a12_p2           <= a12_p1;
      low_cnt          <= a12_p1 ? 3'd0 : sat_inc3(low_cnt);
      counter          <= counter_n;
      latch            <= latch_n;
      presc            <= presc_n;
      enable           <= enable_n;
      enable_after_ack <= enable_after_ack_n;
      cycle_mode       <= cycle_mode_n;
      count_en         <= count_en_n;
      reload_flag      <= reload_flag_n;
      mode_q           <= mode;
      irq              <= ~pending_n;
    end
  end

endmodule
